// File: rtl/dcache_pkg.sv
// Shared types and address-field width helpers for the direct-mapped data cache.
package dcache_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WRITEBACK,
      REFILL
   } dcache_state_t;

   localparam int BYTE_OFF_W = 2;

   function automatic int word_sel_w(input int words_per_line);
      return $clog2(words_per_line);
   endfunction

   function automatic int index_w(input int num_lines);
      return $clog2(num_lines);
   endfunction

   function automatic int tag_w(input int addr_width, input int num_lines, input int words_per_line);
      return addr_width - $clog2(num_lines) - $clog2(words_per_line) - BYTE_OFF_W;
   endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage: asynchronous read, synchronous writes,
// asynchronous active-low clear of the valid and dirty bits only.
module dcache_array
   import dcache_pkg::*;
#(
   parameter  int DATA_WIDTH     = 32,
   parameter  int ADDR_WIDTH     = 32,
   parameter  int NUM_LINES      = 16,
   parameter  int WORDS_PER_LINE = 4,
   localparam int IW             = index_w(NUM_LINES),
   localparam int WW             = word_sel_w(WORDS_PER_LINE),
   localparam int TW             = tag_w(ADDR_WIDTH, NUM_LINES, WORDS_PER_LINE)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [IW-1:0]         rd_index,
   input  logic [WW-1:0]         rd_word,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic [TW-1:0]         rd_tag,
   output logic                  rd_valid,
   output logic                  rd_dirty,
   input  logic [IW-1:0]         wr_index,
   input  logic [WW-1:0]         wr_word,
   input  logic                  word_we,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  meta_we,
   input  logic [TW-1:0]         meta_tag,
   input  logic                  meta_valid,
   input  logic                  meta_dirty
);

   logic [DATA_WIDTH-1:0] data_mem [NUM_LINES*WORDS_PER_LINE];
   logic [TW-1:0]         tag_mem  [NUM_LINES];
   logic [NUM_LINES-1:0]  valid_bits;
   logic [NUM_LINES-1:0]  dirty_bits;

   assign rd_data  = data_mem[{rd_index, rd_word}];
   assign rd_tag   = tag_mem[rd_index];
   assign rd_valid = valid_bits[rd_index];
   assign rd_dirty = dirty_bits[rd_index];

   // NOTE: data and tag storage carry no reset; a line is meaningless until its valid bit is set.
   always_ff @(posedge clk) begin
      if (word_we) data_mem[{wr_index, wr_word}] <= wr_data;
      if (meta_we) tag_mem[wr_index] <= meta_tag;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_bits <= '0;
         dirty_bits <= '0;
      end else if (meta_we) begin
         valid_bits[wr_index] <= meta_valid;
         dirty_bits[wr_index] <= meta_dirty;
      end
   end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache controller for the M stage.
// Defining DCACHE_STATS_EN adds saturating hit_count/miss_count outputs.
module dcache_ctrl
   import dcache_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int NUM_LINES      = 16,
   parameter int WORDS_PER_LINE = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  MemReadM,
   input  logic                  MemWriteM,
   input  logic [ADDR_WIDTH-1:0] ALUResultM,
   input  logic [DATA_WIDTH-1:0] WriteDataM,
   output logic [DATA_WIDTH-1:0] ReadDataM,
   output logic                  StallMem,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_ready
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0]           hit_count,
   output logic [31:0]           miss_count
`endif
);

   localparam int WW = word_sel_w(WORDS_PER_LINE);
   localparam int IW = index_w(NUM_LINES);
   localparam int TW = tag_w(ADDR_WIDTH, NUM_LINES, WORDS_PER_LINE);

   dcache_state_t state, state_next;
   logic [WW-1:0] beat;
   logic [IW-1:0] miss_index;
   logic [TW-1:0] miss_tag;

   logic [WW-1:0]         addr_word;
   logic [IW-1:0]         addr_index;
   logic [TW-1:0]         addr_tag;
   logic [BYTE_OFF_W-1:0] unused_byte_off;

   logic [IW-1:0]         rd_index;
   logic [WW-1:0]         rd_word;
   logic [DATA_WIDTH-1:0] rd_data;
   logic [TW-1:0]         rd_tag;
   logic                  rd_valid, rd_dirty;
   logic [IW-1:0]         wr_index;
   logic [WW-1:0]         wr_word;
   logic                  word_we, meta_we, meta_dirty;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [TW-1:0]         meta_tag;

   logic access, idle_hit, idle_miss, beat_done, last_beat, stall;

   assign addr_word       = ALUResultM[BYTE_OFF_W +: WW];
   assign addr_index      = ALUResultM[BYTE_OFF_W+WW +: IW];
   assign addr_tag        = ALUResultM[ADDR_WIDTH-1 -: TW];
   assign unused_byte_off = ALUResultM[BYTE_OFF_W-1:0];

   // While a line is in flight the array is addressed from the latched miss, not the pipeline.
   assign rd_index = (state == IDLE) ? addr_index : miss_index;
   assign rd_word  = (state == IDLE) ? addr_word  : beat;

   assign access    = MemReadM | MemWriteM;
   assign idle_hit  = (state == IDLE) && access && rd_valid && (rd_tag == addr_tag);
   assign idle_miss = (state == IDLE) && access && !(rd_valid && (rd_tag == addr_tag));
   assign beat_done = mem_req && mem_ready;
   assign last_beat = (beat == WW'(WORDS_PER_LINE - 1));

   // Reset must silence the hazard unit even while a missing access is still presented.
   assign StallMem = stall & reset;

   dcache_array #(
      .DATA_WIDTH    (DATA_WIDTH),
      .ADDR_WIDTH    (ADDR_WIDTH),
      .NUM_LINES     (NUM_LINES),
      .WORDS_PER_LINE(WORDS_PER_LINE)
   ) u_array (
      .clk       (clk),
      .rst_n     (reset),
      .rd_index  (rd_index),
      .rd_word   (rd_word),
      .rd_data   (rd_data),
      .rd_tag    (rd_tag),
      .rd_valid  (rd_valid),
      .rd_dirty  (rd_dirty),
      .wr_index  (wr_index),
      .wr_word   (wr_word),
      .word_we   (word_we),
      .wr_data   (wr_data),
      .meta_we   (meta_we),
      .meta_tag  (meta_tag),
      .meta_valid(1'b1),
      .meta_dirty(meta_dirty)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         beat       <= '0;
         miss_index <= '0;
         miss_tag   <= '0;
      end else begin
         state <= state_next;
         if (beat_done) beat <= beat + 1'b1;
         if (idle_miss) begin
            miss_index <= addr_index;
            miss_tag   <= addr_tag;
         end
      end
   end

   // NOTE: every output of this block is defaulted first so no path can infer a latch.
   always_comb begin
      state_next = state;
      stall      = 1'b0;
      ReadDataM  = '0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      word_we    = 1'b0;
      wr_index   = miss_index;
      wr_word    = beat;
      wr_data    = mem_rdata;
      meta_we    = 1'b0;
      meta_tag   = miss_tag;
      meta_dirty = 1'b0;
      case (state)
         IDLE: begin
            if (idle_hit && MemWriteM) begin
               word_we    = 1'b1;
               wr_index   = addr_index;
               wr_word    = addr_word;
               wr_data    = WriteDataM;
               meta_we    = 1'b1;
               meta_tag   = addr_tag;
               meta_dirty = 1'b1;
            end else if (idle_hit && MemReadM) begin
               ReadDataM = rd_data;
            end else if (idle_miss) begin
               stall      = 1'b1;
               state_next = (rd_valid && rd_dirty) ? WRITEBACK : REFILL;
            end
         end
         WRITEBACK: begin
            stall     = 1'b1;
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = {rd_tag, miss_index, beat, {BYTE_OFF_W{1'b0}}};
            mem_wdata = rd_data;
            if (beat_done && last_beat) state_next = REFILL;
         end
         REFILL: begin
            stall    = 1'b1;
            mem_req  = 1'b1;
            mem_addr = {miss_tag, miss_index, beat, {BYTE_OFF_W{1'b0}}};
            if (beat_done) begin
               word_we = 1'b1;
               if (last_beat) begin
                  meta_we    = 1'b1;
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

`ifdef DCACHE_STATS_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         if (idle_hit && (hit_count != '1)) hit_count <= hit_count + 32'd1;
         if (idle_miss && (miss_count != '1)) miss_count <= miss_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed cache scenarios plus random traffic
// checked against a line-level cache model and a backing-memory responder.
module tb_dcache_ctrl;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
   } beat_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        MemReadM = 1'b0, MemWriteM = 1'b0;
   logic [31:0] ALUResultM = '0, WriteDataM = '0;
   logic [31:0] ReadDataM;
   logic        StallMem, mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic        mem_ready = 1'b0;
`ifdef DCACHE_STATS_EN
   logic [31:0] hit_count, miss_count;
`endif

   dcache_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .MemReadM  (MemReadM),
      .MemWriteM (MemWriteM),
      .ALUResultM(ALUResultM),
      .WriteDataM(WriteDataM),
      .ReadDataM (ReadDataM),
      .StallMem  (StallMem),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready)
`ifdef DCACHE_STATS_EN
      ,
      .hit_count (hit_count),
      .miss_count(miss_count)
`endif
   );

   always #5 clk = ~clk;

   int n_asserts = 0;
   int n_fail    = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Backing memory: words never written read back as a fixed hash of their address.
   logic [31:0] bmem [int unsigned];
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (bmem.exists(a)) return bmem[a];
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
   endfunction

   int    wait_cycles = 0;
   int    wcnt = 0;
   beat_t hold;
   beat_t obs_beats[$];

   always @(negedge clk) begin
      if (mem_req === 1'b1) begin
         if (wcnt == 0) hold = '{mem_we, mem_addr, mem_wdata};
         else begin
            check("hold_we", 64'(mem_we), 64'(hold.we));
            check("hold_addr", 64'(mem_addr), 64'(hold.addr));
            check("hold_wdata", 64'(mem_wdata), 64'(hold.data));
         end
         if (wcnt < wait_cycles) begin
            mem_ready = 1'b0;
            mem_rdata = $urandom;
            wcnt++;
         end else begin
            mem_ready = 1'b1;
            wcnt = 0;
            obs_beats.push_back('{mem_we, mem_addr, mem_wdata});
            if (mem_we) bmem[mem_addr] = mem_wdata;
            else mem_rdata = mem_word(mem_addr);
         end
      end else begin
         mem_ready = 1'($urandom_range(0, 1));
         mem_rdata = $urandom;
         wcnt = 0;
      end
   end

   // Line-level reference model of the cache contents and statistics.
   bit          m_valid [16];
   bit          m_dirty [16];
   logic [23:0] m_tag   [16];
   logic [31:0] m_data  [16][4];
   int          m_hits = 0, m_misses = 0;

   task automatic model_reset();
      for (int i = 0; i < 16; i++) begin
         m_valid[i] = 1'b0;
         m_dirty[i] = 1'b0;
      end
      m_hits = 0;
      m_misses = 0;
   endtask

   task automatic do_access(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] wdata);
      int          idx, w, stalls, exp_stalls;
      bit          hit, done, acc;
      logic [23:0] tag;
      logic [31:0] rf [4];
      logic [31:0] exp_rd, obs_rd;
      beat_t       exp_beats[$];
      idx  = int'(addr[7:4]);
      w    = int'(addr[3:2]);
      tag  = addr[31:8];
      acc  = rd | wr;
      hit  = m_valid[idx] && (m_tag[idx] == tag);
      obs_beats.delete();
      if (acc && !hit) begin
         if (m_valid[idx] && m_dirty[idx])
            for (int k = 0; k < 4; k++)
               exp_beats.push_back('{1'b1, {m_tag[idx], 4'(idx), 2'(k), 2'b00}, m_data[idx][k]});
         for (int k = 0; k < 4; k++) begin
            rf[k] = mem_word({tag, 4'(idx), 2'(k), 2'b00});
            exp_beats.push_back('{1'b0, {tag, 4'(idx), 2'(k), 2'b00}, 32'h0});
         end
      end
      exp_stalls = (acc && !hit) ? 1 + exp_beats.size() * (wait_cycles + 1) : 0;
      if (rd && !wr && acc) exp_rd = hit ? m_data[idx][w] : rf[w];
      else exp_rd = '0;

      MemReadM = rd; MemWriteM = wr; ALUResultM = addr; WriteDataM = wdata;
      stalls = 0; done = 1'b0; obs_rd = 'x;
      for (int c = 0; c < 400 && !done; c++) begin
         @(negedge clk);
         if (StallMem === 1'b1) stalls++;
         else begin
            done = 1'b1;
            obs_rd = ReadDataM;
         end
      end
      @(posedge clk);
      #1;
      MemReadM = 1'b0; MemWriteM = 1'b0;

      check("access_done", 64'(done), 64'(1));
      check("stall_cycles", 64'(stalls), 64'(exp_stalls));
      check("read_data", 64'(obs_rd), 64'(exp_rd));
      check("beat_count", 64'(obs_beats.size()), 64'(exp_beats.size()));
      for (int i = 0; i < exp_beats.size() && i < obs_beats.size(); i++) begin
         check("beat_we", 64'(obs_beats[i].we), 64'(exp_beats[i].we));
         check("beat_addr", 64'(obs_beats[i].addr), 64'(exp_beats[i].addr));
         if (exp_beats[i].we) check("beat_wdata", 64'(obs_beats[i].data), 64'(exp_beats[i].data));
      end

      if (acc) begin
         if (!hit) begin
            m_misses++;
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
            m_tag[idx]   = tag;
            for (int k = 0; k < 4; k++) m_data[idx][k] = rf[k];
         end
         m_hits++;
         if (wr) begin
            m_data[idx][w] = wdata;
            m_dirty[idx]   = 1'b1;
         end
      end
   endtask

   task automatic check_stats();
`ifdef DCACHE_STATS_EN
      check("hit_count", 64'(hit_count), 64'(m_hits));
      check("miss_count", 64'(miss_count), 64'(m_misses));
`endif
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] addr;
      int          nwb, sel;
      model_reset();

      // Reset state, with a load presented to show the outputs stay quiet.
      MemReadM = 1'b1; ALUResultM = 32'h0000_0040;
      repeat (2) @(negedge clk);
      check("rst_stall", 64'(StallMem), 64'(0));
      check("rst_req", 64'(mem_req), 64'(0));
      check("rst_we", 64'(mem_we), 64'(0));
      check("rst_addr", 64'(mem_addr), 64'(0));
      check("rst_wdata", 64'(mem_wdata), 64'(0));
      check("rst_rdata", 64'(ReadDataM), 64'(0));
      @(posedge clk);
      #1;
      MemReadM = 1'b0;
      reset = 1'b1;

      // Cold load, store/load hit, dirty eviction.
      wait_cycles = 0;
      do_access(1'b1, 1'b0, 32'h0000_0040, '0);
      do_access(1'b0, 1'b1, 32'h0000_0044, 32'hDEAD_BEEF);
      do_access(1'b1, 1'b0, 32'h0000_0044, '0);
      do_access(1'b1, 1'b0, 32'h0000_0440, '0);
      if (obs_beats.size() > 1) check("evict_word1", 64'(obs_beats[1].data), 64'h0000_0000_DEAD_BEEF);
      check_stats();

      // Slow memory: three not-ready cycles ahead of every beat.
      wait_cycles = 3;
      do_access(1'b1, 1'b0, 32'h0000_1000, '0);
      wait_cycles = 0;

      // Reset in the middle of refill beat 2.
      addr = 32'h0000_2080;
      nwb  = (m_valid[8] && m_dirty[8]) ? 4 : 0;
      MemReadM = 1'b1; ALUResultM = addr;
      repeat (1 + nwb + 3) @(negedge clk);
      check("abort_beat_addr", 64'(mem_addr), 64'(addr + 32'd8));
      check("abort_beat_req", 64'(mem_req), 64'(1));
      #1 reset = 1'b0;
      #1;
      check("abort_req", 64'(mem_req), 64'(0));
      check("abort_stall", 64'(StallMem), 64'(0));
      check("abort_addr", 64'(mem_addr), 64'(0));
      check("abort_rdata", 64'(ReadDataM), 64'(0));
      model_reset();
      check_stats();
      @(posedge clk);
      #1 reset = 1'b1;
      do_access(1'b1, 1'b0, addr, '0);

      // Random traffic over a few tags so hits, clean misses and evictions all occur.
      for (int n = 0; n < 200; n++) begin
         addr = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 4) |
                (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
         wait_cycles = $urandom_range(0, 2);
         sel = $urandom_range(0, 9);
         if (sel < 5) do_access(1'b1, 1'b0, addr, '0);
         else if (sel < 9) do_access(1'b0, 1'b1, addr, $urandom);
         else do_access(1'b0, 1'b0, addr, '0);
      end
      check_stats();

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
